// File: rtl/wb_arb_if.sv
// Write-back bus between the retirement channels, decode hazard check and register file.
interface wb_arb_if #(
    parameter int unsigned NCH  = 2,
    parameter int unsigned XLEN = 32,
    parameter int unsigned RAW  = 5
);
    logic [NCH-1:0]      ch_valid_i;
    logic [NCH-1:0]      ch_ready_o;
    logic [NCH-1:0]      ch_wen_i;
    logic [NCH*RAW-1:0]  ch_rd_addr_i;
    logic [NCH*XLEN-1:0] ch_rd_data_i;
    logic [RAW-1:0]      rs1_addr_i;
    logic [RAW-1:0]      rs2_addr_i;
    logic                rs1_pend_o;
    logic                rs2_pend_o;
    logic                regs_wen_o;
    logic [RAW-1:0]      rd_addr_o;
    logic [XLEN-1:0]     rd_data_o;
    logic                instret_incr_o;

    // Write-back stage side
    modport slave (
        input  ch_valid_i, ch_wen_i, ch_rd_addr_i, ch_rd_data_i, rs1_addr_i, rs2_addr_i,
        output ch_ready_o, rs1_pend_o, rs2_pend_o, regs_wen_o, rd_addr_o, rd_data_o,
               instret_incr_o
    );

    // Producer / consumer side
    modport master (
        output ch_valid_i, ch_wen_i, ch_rd_addr_i, ch_rd_data_i, rs1_addr_i, rs2_addr_i,
        input  ch_ready_o, rs1_pend_o, rs2_pend_o, regs_wen_o, rd_addr_o, rd_data_o,
               instret_incr_o
    );
endinterface

// File: rtl/wb_arb.sv
// Multi-channel write-back stage: per-channel FIFOs, round-robin retire, pending-rd hazard check.
module wb_arb #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RAW   = 5
) (
    input  logic      clk,
    input  logic      rstn,
    wb_arb_if.slave   bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef struct packed {
        logic            wen;
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            mem_q    [NCH][DEPTH];
    logic [PW-1:0]   wr_ptr_q [NCH];
    logic [PW-1:0]   rd_ptr_q [NCH];
    logic [CW-1:0]   cnt_q    [NCH];
    logic [CW-1:0]   cnt_d    [NCH];
    logic [GW-1:0]   prio_q, prio_d;

    logic            regs_wen_q;
    logic [RAW-1:0]  rd_addr_q;
    logic [XLEN-1:0] rd_data_q;
    logic            instret_q;

    logic [NCH-1:0]  full_c;
    logic [NCH-1:0]  push_c;
    logic [NCH-1:0]  pop_c;
    logic            gnt_c;
    logic [GW-1:0]   gidx_c;
    logic [GW-1:0]   cand_c;
    int unsigned     sum_c;
    ent_t            head_c;
    logic [PW-1:0]   occ_c;
    logic            pend1_c, pend2_c;

    // Occupancy flags and accepted pushes; ready never looks at the same-cycle pop
    always_comb begin
        full_c = '0;
        push_c = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            full_c[k] = (cnt_q[k] == CW'(DEPTH));
            push_c[k] = bus.ch_valid_i[k] & ~full_c[k];
        end
    end

    // Round-robin grant: first non-empty channel at or after prio, cyclically
    always_comb begin
        gnt_c  = 1'b0;
        gidx_c = '0;
        cand_c = '0;
        sum_c  = 0;
        for (int i = 0; i < int'(NCH); i++) begin
            sum_c = 32'(prio_q) + 32'(i);
            if (sum_c >= NCH) begin
                sum_c = sum_c - NCH;
            end
            cand_c = GW'(sum_c);
            if (!gnt_c && (cnt_q[cand_c] != '0)) begin
                gnt_c  = 1'b1;
                gidx_c = cand_c;
            end
        end
    end

    // Pop decode, head selection and next occupancy / priority
    always_comb begin
        pop_c  = '0;
        head_c = mem_q[gidx_c][rd_ptr_q[gidx_c]];
        prio_d = prio_q;
        for (int k = 0; k < int'(NCH); k++) begin
            pop_c[k] = gnt_c && (gidx_c == GW'(k));
            cnt_d[k] = cnt_q[k] + CW'(push_c[k]) - CW'(pop_c[k]);
        end
        if (gnt_c) begin
            prio_d = (gidx_c == GW'(NCH - 1)) ? '0 : gidx_c + GW'(1);
        end
    end

    // Hazard check over all live FIFO entries plus the output stage
    always_comb begin
        pend1_c = 1'b0;
        pend2_c = 1'b0;
        occ_c   = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                occ_c = PW'(e) - rd_ptr_q[k];
                if ((CW'(occ_c) < cnt_q[k]) && mem_q[k][e].wen) begin
                    if (mem_q[k][e].rd == bus.rs1_addr_i) pend1_c = 1'b1;
                    if (mem_q[k][e].rd == bus.rs2_addr_i) pend2_c = 1'b1;
                end
            end
        end
        if (regs_wen_q && (rd_addr_q == bus.rs1_addr_i)) pend1_c = 1'b1;
        if (regs_wen_q && (rd_addr_q == bus.rs2_addr_i)) pend2_c = 1'b1;
        if (bus.rs1_addr_i == '0) pend1_c = 1'b0;
        if (bus.rs2_addr_i == '0) pend2_c = 1'b0;
    end

    // FIFO pointers, counts and arbitration priority
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < int'(NCH); k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            prio_q <= '0;
        end else begin
            for (int k = 0; k < int'(NCH); k++) begin
                if (push_c[k]) wr_ptr_q[k] <= wr_ptr_q[k] + PW'(1);
                if (pop_c[k])  rd_ptr_q[k] <= rd_ptr_q[k] + PW'(1);
                cnt_q[k] <= cnt_d[k];
            end
            prio_q <= prio_d;
        end
    end

    // FIFO storage; contents are only meaningful below count, so no reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(NCH); k++) begin
            if (push_c[k]) begin
                mem_q[k][wr_ptr_q[k]] <= '{wen:  bus.ch_wen_i[k],
                                           rd:   bus.ch_rd_addr_i[k*RAW +: RAW],
                                           data: bus.ch_rd_data_i[k*XLEN +: XLEN]};
            end
        end
    end

    // Registered register-file write port and instret pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            regs_wen_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            instret_q  <= 1'b0;
        end else if (gnt_c) begin
            regs_wen_q <= head_c.wen && (head_c.rd != '0);
            rd_addr_q  <= head_c.rd;
            rd_data_q  <= head_c.data;
            instret_q  <= 1'b1;
        end else begin
            regs_wen_q <= 1'b0;
            instret_q  <= 1'b0;
        end
    end

    assign bus.ch_ready_o     = ~full_c;
    assign bus.rs1_pend_o     = pend1_c;
    assign bus.rs2_pend_o     = pend2_c;
    assign bus.regs_wen_o     = regs_wen_q;
    assign bus.rd_addr_o      = rd_addr_q;
    assign bus.rd_data_o      = rd_data_q;
    assign bus.instret_incr_o = instret_q;
endmodule

// File: tb/tb_wb_arb.sv
// Randomised and directed bench for wb_arb against a queue-based reference model.
module tb_wb_arb;
    localparam int unsigned NCH   = 2;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned RAW   = 5;

    typedef struct packed {
        logic            wen;
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] data;
    } ent_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    wb_arb_if #(.NCH(NCH), .XLEN(XLEN), .RAW(RAW)) bus ();

    wb_arb #(.NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN), .RAW(RAW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Reference model state
    ent_t            mq [NCH][$];
    int              m_prio;
    logic            m_wen;
    logic            m_inst;
    logic [RAW-1:0]  m_rd;
    logic [XLEN-1:0] m_data;
    int              n_acc;
    int              n_ret;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic model_pend(input logic [RAW-1:0] a);
        if (a == '0) return 1'b0;
        for (int k = 0; k < int'(NCH); k++)
            for (int i = 0; i < mq[k].size(); i++)
                if (mq[k][i].wen && mq[k][i].rd == a) return 1'b1;
        return m_wen && (m_rd == a);
    endfunction

    function automatic logic [NCH-1:0] model_ready();
        logic [NCH-1:0] r;
        for (int k = 0; k < int'(NCH); k++) r[k] = (mq[k].size() < int'(DEPTH));
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < int'(NCH); k++) mq[k].delete();
        m_prio = 0;
        m_wen  = 1'b0;
        m_inst = 1'b0;
        m_rd   = '0;
        m_data = '0;
    endtask

    task automatic check_outputs();
        check("regs_wen", 64'(bus.regs_wen_o),     64'(m_wen));
        check("rd_addr",  64'(bus.rd_addr_o),      64'(m_rd));
        check("rd_data",  64'(bus.rd_data_o),      64'(m_data));
        check("instret",  64'(bus.instret_incr_o), 64'(m_inst));
        check("ready",    64'(bus.ch_ready_o),     64'(model_ready()));
    endtask

    // One clock: apply inputs, check hazards, clock the edge, update model, check outputs
    task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] w,
                        input logic [NCH*RAW-1:0] rd, input logic [NCH*XLEN-1:0] d,
                        input logic [RAW-1:0] a1, input logic [RAW-1:0] a2);
        logic [NCH-1:0] acc;
        int   g;
        ent_t e;
        bus.ch_valid_i   = v;
        bus.ch_wen_i     = w;
        bus.ch_rd_addr_i = rd;
        bus.ch_rd_data_i = d;
        bus.rs1_addr_i   = a1;
        bus.rs2_addr_i   = a2;
        #1;
        check("rs1_pend", 64'(bus.rs1_pend_o), 64'(model_pend(a1)));
        check("rs2_pend", 64'(bus.rs2_pend_o), 64'(model_pend(a2)));
        @(posedge clk);
        acc = v & model_ready();
        g = -1;
        for (int i = 0; i < int'(NCH); i++) begin
            int j;
            j = (m_prio + i) % int'(NCH);
            if (g < 0 && mq[j].size() > 0) g = j;
        end
        if (g >= 0) begin
            e      = mq[g].pop_front();
            m_wen  = e.wen && (e.rd != '0);
            m_rd   = e.rd;
            m_data = e.data;
            m_inst = 1'b1;
            m_prio = (g + 1) % int'(NCH);
        end else begin
            m_wen  = 1'b0;
            m_inst = 1'b0;
        end
        for (int k = 0; k < int'(NCH); k++) begin
            if (acc[k]) begin
                e.wen  = w[k];
                e.rd   = rd[k*RAW +: RAW];
                e.data = d[k*XLEN +: XLEN];
                mq[k].push_back(e);
                n_acc++;
            end
        end
        #1;
        check_outputs();
        if (bus.instret_incr_o) n_ret++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, '0, '0, '0);
    endtask

    initial begin
        logic [NCH*RAW-1:0]  rdv;
        logic [NCH*XLEN-1:0] dv;
        logic                seen_drop;

        bus.ch_valid_i   = '0;
        bus.ch_wen_i     = '0;
        bus.ch_rd_addr_i = '0;
        bus.ch_rd_data_i = '0;
        bus.rs1_addr_i   = '0;
        bus.rs2_addr_i   = '0;
        n_acc = 0;
        n_ret = 0;
        model_reset();

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_regs_wen", 64'(bus.regs_wen_o), 64'(0));
        check("rst_instret",  64'(bus.instret_incr_o), 64'(0));
        rstn = 1'b1;
        #1;
        check("rst_ready", 64'(bus.ch_ready_o), 64'({NCH{1'b1}}));
        check_outputs();

        // Single write through channel 0
        step(2'b01, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, '0, '0);
        check("sw_not_yet", 64'(bus.instret_incr_o), 64'(0));
        idle(1);
        check("sw_wen",  64'(bus.regs_wen_o), 64'(1));
        check("sw_addr", 64'(bus.rd_addr_o),  64'(5));
        check("sw_data", 64'(bus.rd_data_o),  64'(32'hDEADBEEF));
        check("sw_inst", 64'(bus.instret_incr_o), 64'(1));
        idle(1);
        check("sw_end_wen",  64'(bus.regs_wen_o), 64'(0));
        check("sw_end_inst", 64'(bus.instret_incr_o), 64'(0));

        // x0 destination and wen=0 both retire without a write
        step(2'b01, 2'b01, {5'd0, 5'd0}, {32'h0, 32'h1111}, '0, '0);
        idle(1);
        check("x0_inst", 64'(bus.instret_incr_o), 64'(1));
        check("x0_wen",  64'(bus.regs_wen_o), 64'(0));
        step(2'b01, 2'b00, {5'd0, 5'd3}, {32'h0, 32'h2222}, 5'd3, '0);
        idle(1);
        check("nowen_inst", 64'(bus.instret_incr_o), 64'(1));
        check("nowen_wen",  64'(bus.regs_wen_o), 64'(0));
        idle(1);

        // Round-robin with channel-tagged counters
        for (int n = 0; n < 8; n++)
            step(2'b11, 2'b11, {5'd2, 5'd1},
                 {32'hB000_0000 + 32'(n), 32'hA000_0000 + 32'(n)}, '0, '0);
        idle(6);

        // Pending hazard on rd=7 held in channel 1
        step(2'b11, 2'b11, {5'd7, 5'd4}, {32'h77, 32'h44}, '0, '0);
        bus.ch_valid_i = '0;
        bus.rs1_addr_i = 5'd7;
        bus.rs2_addr_i = 5'd0;
        #1;
        check("pend_rs1", 64'(bus.rs1_pend_o), 64'(1));
        check("pend_rs2", 64'(bus.rs2_pend_o), 64'(0));
        for (int n = 0; n < 5; n++) step('0, '0, '0, '0, 5'd7, 5'd4);
        check("pend_rs1_clear", 64'(bus.rs1_pend_o), 64'(0));

        // Backpressure: both channels push for 8 cycles, then drain
        n_acc = 0;
        n_ret = 0;
        seen_drop = 1'b0;
        for (int n = 0; n < 8; n++) begin
            step(2'b11, 2'b11, {5'd9, 5'd8},
                 {32'hD000_0000 + 32'(n), 32'hC000_0000 + 32'(n)}, 5'd8, 5'd9);
            if (bus.ch_ready_o != {NCH{1'b1}}) seen_drop = 1'b1;
        end
        idle(10);
        check("bp_ready_drop", 64'(seen_drop), 64'(1));
        check("bp_retired", 64'(n_ret), 64'(n_acc));

        // Randomised traffic with hazard probes
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < int'(NCH); k++) begin
                rdv[k*RAW +: RAW]   = RAW'($urandom_range(0, 7));
                dv[k*XLEN +: XLEN]  = XLEN'($urandom);
            end
            step(NCH'($urandom), NCH'($urandom), rdv, dv,
                 RAW'($urandom_range(0, 7)), RAW'($urandom_range(0, 7)));
        end

        // Reset mid-traffic discards buffered entries
        for (int n = 0; n < 3; n++)
            step(2'b11, 2'b11, {5'd6, 5'd6}, {32'h66, 32'h65}, '0, '0);
        bus.ch_valid_i = '0;
        rstn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        check_outputs();
        n_ret = 0;
        idle(4);
        check("rst_no_pulse", 64'(n_ret), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
